// File: rtl/clock_time_set.sv
// Time-setting front end for the digital clock.
// Cleans up the MODE and INC buttons, runs the RUN -> SET_HRS -> SET_MIN edit
// sequence on a private copy of the time, and hands the edited value to the
// counter stage with a one-cycle load strobe.
module clock_time_set #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int REPEAT_DELAY    = 13500000,
   parameter int REPEAT_RATE     = 2700000,
   parameter int BLINK_HALF      = 6750000,
   parameter int TIMEOUT_BLINKS  = 40
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       btn_mode_n,
   input  logic       btn_inc_n,
   input  logic [3:0] cur_hrs_1,
   input  logic [3:0] cur_hrs_0,
   input  logic [3:0] cur_min_1,
   input  logic [3:0] cur_min_0,
   output logic       set_load,
   output logic [3:0] set_hrs_1,
   output logic [3:0] set_hrs_0,
   output logic [3:0] set_min_1,
   output logic [3:0] set_min_0,
   output logic       set_active,
   output logic [3:0] digit_blank
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W  = $clog2(REPEAT_DELAY + 1);
   localparam int BLINK_W = $clog2(BLINK_HALF + 1);
   localparam int IDLE_W  = $clog2(TIMEOUT_BLINKS + 1);

   localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);
   localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);
   localparam logic [IDLE_W-1:0]  IDLE_LAST   = IDLE_W'(TIMEOUT_BLINKS - 1);

   typedef enum logic [1:0] {RUN, SET_HRS, SET_MIN, COMMIT} state_t;

   // Index 0 is the MODE button, index 1 is the INC button.
   logic [1:0]            sync_a;
   logic [1:0]            sync_b;
   logic [1:0]            btn_deb;
   logic [1:0]            btn_press;
   logic [1:0][DB_W-1:0]  db_cnt;

   logic [HOLD_W-1:0]     hold_cnt;
   logic                  rpt_pulse;

   state_t                state;
   logic [BLINK_W-1:0]    blink_cnt;
   logic                  phase;
   logic [IDLE_W-1:0]     idle_cnt;

   logic                  mode_press;
   logic                  inc_evt;
   logic                  blink_tick;
   logic                  phase_nx;
   logic                  timeout_hit;
   logic                  hrs_over;

   assign mode_press  = btn_press[0];
   assign inc_evt     = btn_press[1] | rpt_pulse;
   assign blink_tick  = (blink_cnt == BLINK_LAST);
   assign phase_nx    = (inc_evt && !mode_press) ? 1'b0 : (phase ^ blink_tick);
   assign timeout_hit = blink_tick && (idle_cnt == IDLE_LAST);
   assign hrs_over    = (cur_hrs_1 > 4'd2) || ((cur_hrs_1 == 4'd2) && (cur_hrs_0 > 4'd3));

   // BCD hours step, 23 wraps to 00.
   function automatic logic [7:0] hrs_inc(input logic [3:0] t, input logic [3:0] u);
      if (t == 4'd2 && u == 4'd3) hrs_inc = 8'h00;
      else if (u == 4'd9)         hrs_inc = {t + 4'd1, 4'd0};
      else                        hrs_inc = {t, u + 4'd1};
   endfunction

   // BCD minutes step, 59 wraps to 00 without touching the hours.
   function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
      if (u != 4'd9)       min_inc = {t, u + 4'd1};
      else if (t == 4'd5)  min_inc = 8'h00;
      else                 min_inc = {t + 4'd1, 4'd0};
   endfunction

   // Two-stage synchroniser for the raw buttons; idles at released (high).
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_a <= 2'b11;
         sync_b <= 2'b11;
      end else begin
         sync_a <= {btn_inc_n, btn_mode_n};
         sync_b <= sync_a;
      end
   end

   // Accept a new level only after it has been stable long enough; a press is the accepted 1->0 step.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         btn_deb   <= 2'b11;
         btn_press <= 2'b00;
         db_cnt    <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            btn_press[i] <= 1'b0;
            if (sync_b[i] == btn_deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               btn_deb[i]   <= sync_b[i];
               db_cnt[i]    <= '0;
               btn_press[i] <= ~sync_b[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Auto-repeat while INC is held: first extra step after the long delay, then at the faster rate.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold_cnt  <= '0;
         rpt_pulse <= 1'b0;
      end else begin
         rpt_pulse <= 1'b0;
         if (btn_deb[1]) begin
            hold_cnt <= '0;
         end else if (hold_cnt == HOLD_LAST) begin
            rpt_pulse <= 1'b1;
            hold_cnt  <= HOLD_RELOAD;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   // Edit state machine with blink, idle timeout and registered outputs; MODE beats INC when both arrive together.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= RUN;
         set_load    <= 1'b0;
         set_active  <= 1'b0;
         digit_blank <= 4'b0000;
         set_hrs_1   <= 4'd0;
         set_hrs_0   <= 4'd0;
         set_min_1   <= 4'd0;
         set_min_0   <= 4'd0;
         blink_cnt   <= '0;
         phase       <= 1'b0;
         idle_cnt    <= '0;
      end else begin
         set_load <= 1'b0;
         case (state)
            RUN: begin
               blink_cnt   <= '0;
               phase       <= 1'b0;
               idle_cnt    <= '0;
               digit_blank <= 4'b0000;
               set_active  <= mode_press;
               if (mode_press) begin
                  if (hrs_over) begin
                     set_hrs_1 <= 4'd0;
                     set_hrs_0 <= 4'd0;
                  end else begin
                     set_hrs_1 <= cur_hrs_1;
                     set_hrs_0 <= cur_hrs_0;
                  end
                  set_min_1 <= cur_min_1;
                  set_min_0 <= cur_min_0;
                  state     <= SET_HRS;
               end
            end
            SET_HRS, SET_MIN: begin
               if (mode_press) begin
                  idle_cnt  <= '0;
                  blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
                  phase     <= phase_nx;
                  if (state == SET_HRS) begin
                     state       <= SET_MIN;
                     digit_blank <= {2'b00, phase_nx, phase_nx};
                  end else begin
                     state       <= COMMIT;
                     set_load    <= 1'b1;
                     set_active  <= 1'b0;
                     digit_blank <= 4'b0000;
                  end
               end else if (timeout_hit && !inc_evt) begin
                  state       <= RUN;
                  set_active  <= 1'b0;
                  digit_blank <= 4'b0000;
                  blink_cnt   <= '0;
                  phase       <= 1'b0;
                  idle_cnt    <= '0;
               end else begin
                  if (inc_evt) begin
                     idle_cnt  <= '0;
                     blink_cnt <= '0;
                     phase     <= 1'b0;
                     if (state == SET_HRS) {set_hrs_1, set_hrs_0} <= hrs_inc(set_hrs_1, set_hrs_0);
                     else                  {set_min_1, set_min_0} <= min_inc(set_min_1, set_min_0);
                  end else begin
                     blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
                     phase     <= phase_nx;
                     if (blink_tick) idle_cnt <= idle_cnt + 1'b1;
                  end
                  digit_blank <= (state == SET_HRS) ? {phase_nx, phase_nx, 2'b00}
                                                    : {2'b00, phase_nx, phase_nx};
               end
            end
            COMMIT: begin
               state       <= RUN;
               set_active  <= 1'b0;
               digit_blank <= 4'b0000;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule
